// File: rtl/freq_div_ctrl.sv
// Programmable 50%-duty clock divider with clean start/stop; tick_cnt counter built only
// when FREQ_DIV_CTRL_TICK_CNT_EN is defined (otherwise the port is tied to 0).
module freq_div_ctrl #(
   parameter int CNT_W        = 16,
   parameter int DEFAULT_HALF = 500
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             clk_out,
   output logic             tick,
   output logic [31:0]      tick_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] half_q;
   logic [CNT_W-1:0] half_d;
   logic             clk_out_q;
   logic             tick_q;
   logic             busy_q;
   logic             cfg_ready_q;
   logic             boundary;

   // half_q is never 0, so half_q-1 cannot underflow.
   assign boundary = (cnt_q == half_q - CNT_W'(1));
   assign cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
   assign half_d   = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         half_q      <= CNT_W'(DEFAULT_HALF);
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         tick_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_valid) half_q <= half_d;
               if (start) begin
                  state_q     <= RUN;
                  busy_q      <= 1'b1;
                  cfg_ready_q <= 1'b0;
                  cnt_q       <= '0;
                  clk_out_q   <= 1'b0;
               end
            end
            RUN: begin
               cnt_q <= cnt_d;
               if (boundary) begin
                  clk_out_q <= ~clk_out_q;
                  tick_q    <= 1'b1;
               end
               if (stop) state_q <= STOPPING;
            end
            STOPPING: begin
               cnt_q <= cnt_d;
               // Finish the current phase so no output phase is ever shortened.
               if (boundary) begin
                  if (clk_out_q) begin
                     clk_out_q <= 1'b0;
                     tick_q    <= 1'b1;
                  end
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  cfg_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               cfg_ready_q <= 1'b1;
               clk_out_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
   logic [31:0] tick_cnt_q;

   // Rising edges only happen in RUN; STOPPING can only lower clk_out.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else if (state_q == IDLE && start) begin
         tick_cnt_q <= '0;
      end else if (state_q == RUN && boundary && !clk_out_q) begin
         tick_cnt_q <= tick_cnt_q + 32'd1;
      end
   end

   assign tick_cnt = tick_cnt_q;
`else
   assign tick_cnt = '0;
`endif

   assign cfg_ready = cfg_ready_q;
   assign busy      = busy_q;
   assign clk_out   = clk_out_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_freq_div_ctrl;

   localparam int CNT_W = 16;
`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
   localparam bit TC_EN = 1'b1;
`else
   localparam bit TC_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_ready;
   logic             start;
   logic             stop;
   logic             busy;
   logic             clk_out;
   logic             tick;
   logic [31:0]      tick_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   freq_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(500)) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_half  (cfg_half),
      .cfg_ready (cfg_ready),
      .start     (start),
      .stop      (stop),
      .busy      (busy),
      .clk_out   (clk_out),
      .tick      (tick),
      .tick_cnt  (tick_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".busy"},      32'(busy),      32'd0);
      check_eq({tag, ".clk_out"},   32'(clk_out),   32'd0);
      check_eq({tag, ".tick"},      32'(tick),      32'd0);
      check_eq({tag, ".tick_cnt"},  tick_cnt,       32'd0);
      check_eq({tag, ".cfg_ready"}, 32'(cfg_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1; cfg_valid = 1'b0; cfg_half = '0; start = 1'b0; stop = 1'b0;
      #1;
      steps(2);
      reset = 1'b0;
      check_reset_outputs("rst");

      // Default divide-by-1000 run.
      start = 1'b1; steps(1); start = 1'b0;
      check_eq("def.busy_e0", 32'(busy), 32'd1);
      check_eq("def.cfg_ready_e0", 32'(cfg_ready), 32'd0);
      check_eq("def.clk_e0", 32'(clk_out), 32'd0);
      steps(499);
      check_eq("def.clk_e499", 32'(clk_out), 32'd0);
      check_eq("def.tick_e499", 32'(tick), 32'd0);
      steps(1);
      check_eq("def.clk_e500", 32'(clk_out), 32'd1);
      check_eq("def.tick_e500", 32'(tick), 32'd1);
      steps(1);
      check_eq("def.tick_e501", 32'(tick), 32'd0);
      steps(499);
      check_eq("def.clk_e1000", 32'(clk_out), 32'd0);
      check_eq("def.tick_e1000", 32'(tick), 32'd1);
      check_eq("def.tick_cnt_e1000", tick_cnt, TC_EN ? 32'd1 : 32'd0);

      // Reset beats a simultaneous start mid-run.
      reset = 1'b1; start = 1'b1; steps(1); reset = 1'b0; start = 1'b0;
      check_reset_outputs("rst_run");

      // Config and start in the same cycle; half=3.
      cfg_valid = 1'b1; cfg_half = 16'd3; start = 1'b1;
      steps(1);
      cfg_valid = 1'b0; start = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         steps(1);
         check_eq($sformatf("h3.clk_e%0d", k), 32'(clk_out), 32'((k / 3) % 2));
         check_eq($sformatf("h3.tick_e%0d", k), 32'(tick), 32'(k % 3 == 0));
      end
      check_eq("h3.tick_cnt_e24", tick_cnt, TC_EN ? 32'd4 : 32'd0);
      start = 1'b1; steps(1); start = 1'b0;
      check_eq("h3.start_ignored_clk_e25", 32'(clk_out), 32'd0);
      check_eq("h3.start_ignored_tick_cnt", tick_cnt, TC_EN ? 32'd4 : 32'd0);
      reset = 1'b1; steps(1); reset = 1'b0;

      // half=4, stop sampled as counter becomes 1 during high phase.
      cfg_valid = 1'b1; cfg_half = 16'd4; steps(1); cfg_valid = 1'b0;
      start = 1'b1; steps(1); start = 1'b0;
      steps(4);
      check_eq("h4hi.clk_e4", 32'(clk_out), 32'd1);
      stop = 1'b1; steps(1); stop = 1'b0;
      check_eq("h4hi.busy_e5", 32'(busy), 32'd1);
      check_eq("h4hi.clk_e5", 32'(clk_out), 32'd1);
      steps(2);
      check_eq("h4hi.clk_e7", 32'(clk_out), 32'd1);
      check_eq("h4hi.busy_e7", 32'(busy), 32'd1);
      steps(1);
      check_eq("h4hi.clk_e8", 32'(clk_out), 32'd0);
      check_eq("h4hi.tick_e8", 32'(tick), 32'd1);
      check_eq("h4hi.busy_e8", 32'(busy), 32'd0);
      check_eq("h4hi.cfg_ready_e8", 32'(cfg_ready), 32'd1);
      check_eq("h4hi.tick_cnt_e8", tick_cnt, TC_EN ? 32'd1 : 32'd0);
      stop = 1'b1; steps(1); stop = 1'b0;
      check_eq("h4hi.clk_e9", 32'(clk_out), 32'd0);
      check_eq("h4hi.tick_e9", 32'(tick), 32'd0);
      check_eq("h4hi.stop_idle_busy", 32'(busy), 32'd0);

      // half=4, stop during low phase; cfg offered while busy is refused.
      start = 1'b1; steps(1); start = 1'b0;
      cfg_valid = 1'b1; cfg_half = 16'd9;
      check_eq("h4lo.cfg_ready_e0", 32'(cfg_ready), 32'd0);
      steps(1);
      stop = 1'b1; steps(1); stop = 1'b0;
      check_eq("h4lo.cfg_ready_e2", 32'(cfg_ready), 32'd0);
      steps(1);
      cfg_valid = 1'b0;
      check_eq("h4lo.busy_e3", 32'(busy), 32'd1);
      steps(1);
      check_eq("h4lo.busy_e4", 32'(busy), 32'd0);
      check_eq("h4lo.clk_e4", 32'(clk_out), 32'd0);
      check_eq("h4lo.tick_e4", 32'(tick), 32'd0);
      start = 1'b1; steps(1); start = 1'b0;
      steps(3);
      check_eq("h4lo.keep_half_clk_e3", 32'(clk_out), 32'd0);
      steps(1);
      check_eq("h4lo.keep_half_clk_e4", 32'(clk_out), 32'd1);

      // Reset mid-run, then cfg_half=0 behaves as 1.
      reset = 1'b1; stop = 1'b1; cfg_valid = 1'b1; cfg_half = 16'd7;
      steps(1);
      reset = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      check_reset_outputs("rst_h4");
      cfg_valid = 1'b1; cfg_half = 16'd0; steps(1); cfg_valid = 1'b0;
      start = 1'b1; stop = 1'b1; steps(1); start = 1'b0; stop = 1'b0;
      check_eq("h0.start_stop_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         steps(1);
         check_eq($sformatf("h0.clk_e%0d", k), 32'(clk_out), 32'(k % 2));
         check_eq($sformatf("h0.tick_e%0d", k), 32'(tick), 32'd1);
      end
      check_eq("h0.tick_cnt_e3", tick_cnt, TC_EN ? 32'd2 : 32'd0);
      reset = 1'b1; steps(1); reset = 1'b0;
      check_reset_outputs("rst_h0");

      // Reset restores the default half-period.
      start = 1'b1; steps(1); start = 1'b0;
      steps(499);
      check_eq("rst_half.clk_e499", 32'(clk_out), 32'd0);
      steps(1);
      check_eq("rst_half.clk_e500", 32'(clk_out), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
